// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - drains the camera FIFO in fixed bursts into a double-buffered SDRAM frame store
module frame_buffer_writer #(
    parameter int unsigned       BURST_LEN    = 512,
    parameter int unsigned       FRAME_PIXELS = 307200,
    parameter int unsigned       ADDR_W       = 24,
    parameter logic [ADDR_W-1:0] BANK0_BASE   = 24'h000000,
    parameter logic [ADDR_W-1:0] BANK1_BASE   = 24'h080000
) (
    input  logic              clk_100,
    input  logic              rst_n,
    input  logic [9:0]        fifo_count,
    input  logic [15:0]       fifo_dout,
    output logic              fifo_rd_en,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [15:0]       wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              frame_done,
    output logic              disp_bank
);
    localparam logic [9:0]  BURST_W = 10'(BURST_LEN);
    localparam logic [9:0]  LAST_W  = 10'(BURST_LEN - 1);
    localparam logic [18:0] STEP_W  = 19'(BURST_LEN);
    localparam logic [18:0] FRAME_W = 19'(FRAME_PIXELS);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_ADV} state_t;
    state_t state_q, state_d;

    logic [18:0]       offset_q;
    logic              wr_bank_q;
    logic              disp_bank_q;
    logic              frame_done_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [9:0]        issued_q;
    logic [9:0]        sent_q;

    logic [15:0]       buf_mem [2];
    logic              buf_rd_ptr;
    logic              buf_wr_ptr;
    logic [1:0]        buf_cnt;
    logic              in_flight_q;

    logic              xfer;
    logic              last_xfer;
    logic              frame_end;
    logic              store_arrival;
    logic              pop_stored;
    logic [18:0]       offset_next;
    logic [ADDR_W-1:0] base_addr;

    assign offset_next = offset_q + STEP_W;
    assign frame_end   = (offset_next == FRAME_W);
    assign base_addr   = wr_bank_q ? BANK1_BASE : BANK0_BASE;

    // The word arriving on fifo_dout counts as buffered in the cycle after its read,
    // so it is forwarded directly when nothing older is stored ahead of it.
    assign wr_valid      = (buf_cnt != 2'd0) || in_flight_q;
    assign wr_data       = (buf_cnt != 2'd0) ? buf_mem[buf_rd_ptr] :
                           (in_flight_q ? fifo_dout : 16'h0000);
    assign xfer          = wr_valid && wr_ready;
    assign pop_stored    = xfer && (buf_cnt != 2'd0);
    assign store_arrival = in_flight_q && !(xfer && (buf_cnt == 2'd0));
    assign last_xfer     = (state_q == S_DATA) && xfer && (sent_q == LAST_W);

    assign fifo_rd_en = (state_q == S_DATA) && (issued_q < BURST_W) &&
                        ((buf_cnt + {1'b0, in_flight_q}) < 2'd2);
    assign cmd_valid  = (state_q == S_CMD);
    assign cmd_addr   = cmd_addr_q;
    assign frame_done = frame_done_q;
    assign disp_bank  = disp_bank_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fifo_count >= BURST_W) state_d = S_CMD;
            S_CMD:   if (cmd_ready) state_d = S_DATA;
            S_DATA:  if (last_xfer) state_d = S_ADV;
            S_ADV:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            offset_q     <= '0;
            wr_bank_q    <= 1'b0;
            disp_bank_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cmd_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= 1'b0;
            if (state_q == S_IDLE && state_d == S_CMD) begin
                cmd_addr_q <= base_addr + ADDR_W'(offset_q);
            end
            // Frame completion is flagged on entry to ADV so the pulse spans the ADV cycle.
            if (last_xfer && frame_end) begin
                frame_done_q <= 1'b1;
                disp_bank_q  <= wr_bank_q;
            end
            if (state_q == S_ADV) begin
                if (frame_end) begin
                    offset_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    offset_q  <= offset_next;
                end
            end
        end
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            sent_q   <= '0;
        end else if (state_q == S_CMD && cmd_ready) begin
            issued_q <= '0;
            sent_q   <= '0;
        end else begin
            if (fifo_rd_en) issued_q <= issued_q + 10'd1;
            if (state_q == S_DATA && xfer) sent_q <= sent_q + 10'd1;
        end
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            buf_mem[0]  <= 16'h0000;
            buf_mem[1]  <= 16'h0000;
            buf_rd_ptr  <= 1'b0;
            buf_wr_ptr  <= 1'b0;
            buf_cnt     <= 2'd0;
            in_flight_q <= 1'b0;
        end else begin
            in_flight_q <= fifo_rd_en;
            if (store_arrival) begin
                buf_mem[buf_wr_ptr] <= fifo_dout;
                buf_wr_ptr          <= ~buf_wr_ptr;
            end
            if (pop_stored) buf_rd_ptr <= ~buf_rd_ptr;
            buf_cnt <= buf_cnt + {1'b0, store_arrival} - {1'b0, pop_stored};
        end
    end
endmodule
